packed_act_stream_reader: RTL and testbench

Reader side of the 4-bit packed activation buffer. Eight ReLU6 activations are packed per 32-bit BRAM word, with the first pixel in [31:28]. This block walks a full feature map (NUM_FILT channels of IM_W*IM_H pixels) through the BRAM read port. It unpacks the nibbles and streams them one per handshake, in channel-major, raster order, to the next layer's valid/ready input.

---
 rtl/packed_act_pkg.sv | 13 +
 rtl/packed_word_fifo.sv | 53 +++++
 rtl/packed_act_stream_reader.sv | 99 +++++++++
 tb/tb_packed_act_stream_reader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/packed_act_pkg.sv
// packed_act_pkg: geometry, reader states and nibble helpers shared by the packed activation reader and writer
package packed_act_pkg;
    localparam int NIBBLES_PER_WORD = 8;
    localparam logic [3:0] RELU6_MAX = 4'd6;
    typedef enum logic [1:0] {IDLE, RUN, DONE} rd_state_t;
    // nibble 0 (first pixel) is the top nibble of the word
    function automatic logic [3:0] nib_extract(input logic [31:0] word, input logic [2:0] k);
        return 4'(word >> (5'd28 - {k, 2'b00}));
    endfunction
    function automatic logic [31:0] word_byte_addr(input int ch, input int pix, input int im_w, input int im_h);
        return 32'(((ch * im_w * im_h + pix) / NIBBLES_PER_WORD) * 4);
    endfunction
endpackage

// File: rtl/packed_word_fifo.sv
// packed_word_fifo: 2-entry word FIFO fed by a BRAM_LAT-deep read-valid pipe, with an outstanding-read credit count
module packed_word_fifo #(
    parameter int BRAM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        issue,
    input  logic [31:0] rd_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic        empty,
    output logic        credit_ok
);
    logic [BRAM_LAT-1:0] vpipe;
    logic [31:0] mem [2];
    logic [1:0] count;
    logic [1:0] outstanding;
    logic rp;
    logic wp;
    logic push;
    assign push = vpipe[BRAM_LAT-1];
    assign head = mem[rp];
    assign empty = count == 2'd0;
    // reads in flight reserve a slot, so a returning word always finds room
    assign credit_ok = ({1'b0, count} + {1'b0, outstanding}) < 3'd2;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vpipe <= '0;
            count <= '0;
            outstanding <= '0;
            rp <= 1'b0;
            wp <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            vpipe <= '0;
            count <= '0;
            outstanding <= '0;
            rp <= 1'b0;
            wp <= 1'b0;
        end else begin
            vpipe <= BRAM_LAT'({vpipe, issue});
            count <= count + {1'b0, push} - {1'b0, pop};
            outstanding <= outstanding + {1'b0, issue} - {1'b0, push};
            if (push) begin
                mem[wp] <= rd_data;
                wp <= ~wp;
            end
            if (pop) rp <= ~rp;
        end
    end
endmodule

// File: rtl/packed_act_stream_reader.sv
// packed_act_stream_reader: walks a 4-bit packed feature map out of BRAM and streams one nibble per handshake.
// Define PACKED_ACT_RANGE_CHECK_EN to flag handshaken nibbles above RELU6_MAX on the sticky range_err.
module packed_act_stream_reader
    import packed_act_pkg::*;
#(
    parameter int IM_W     = 32,
    parameter int IM_H     = 32,
    parameter int NUM_FILT = 32,
    parameter int BRAM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic        bram_en,
    output logic [31:0] bram_addr,
    input  logic [31:0] bram_dout,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [3:0]  m_data,
    output logic [5:0]  m_ch,
    output logic [9:0]  m_idx,
    output logic        m_last_ch,
    output logic        m_last,
    output logic        busy,
    output logic        done,
    output logic        range_err
);
    localparam int PIX = IM_W * IM_H;
    localparam int TOTAL_WORDS = NUM_FILT * PIX / NIBBLES_PER_WORD;
    rd_state_t state, state_nx;
    logic [31:0] rd_word;
    logic [2:0] nib_sel;
    logic [31:0] head;
    logic empty, credit_ok, run, beat, pop, clr, accept;
    assign run = state == RUN && !abort;
    assign accept = state == IDLE && start && !abort;
    assign bram_en = run && rd_word < 32'(TOTAL_WORDS) && credit_ok;
    assign bram_addr = rd_word << 2;
    assign m_valid = run && !empty;
    assign beat = m_valid && m_ready;
    assign pop = beat && nib_sel == 3'd7;
    assign clr = abort || state == DONE;
    assign m_data = m_valid ? nib_extract(head, nib_sel) : 4'd0;
    assign m_last_ch = m_idx == 10'(PIX - 1);
    assign m_last = m_last_ch && m_ch == 6'(NUM_FILT - 1);
    assign busy = state == RUN;
    assign done = state == DONE;
    packed_word_fifo #(.BRAM_LAT(BRAM_LAT)) u_fifo (
        .clk(clk),
        .reset(reset),
        .flush(abort),
        .issue(bram_en),
        .rd_data(bram_dout),
        .pop(pop),
        .head(head),
        .empty(empty),
        .credit_ok(credit_ok)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (abort || state == DONE) state_nx = IDLE;
        else if (accept) state_nx = RUN;
        else if (beat && m_last) state_nx = DONE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset || 1'b0) begin
            rd_word <= '0;
            nib_sel <= '0;
            m_ch <= '0;
            m_idx <= '0;
        end else if (clr) begin
            rd_word <= '0;
            nib_sel <= '0;
            m_ch <= '0;
            m_idx <= '0;
        end else begin
            if (bram_en) rd_word <= rd_word + 32'd1;
            if (beat) begin
                nib_sel <= nib_sel + 3'd1;
                m_idx <= m_last_ch ? 10'd0 : m_idx + 10'd1;
                if (m_last_ch) m_ch <= m_ch + 6'd1;
            end
        end
    end
`ifdef PACKED_ACT_RANGE_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) range_err <= 1'b0;
        else if (accept) range_err <= 1'b0;
        else if (beat && m_data > RELU6_MAX) range_err <= 1'b1;
    end
`else
    assign range_err = 1'b0;
`endif
endmodule

// File: tb/tb_packed_act_stream_reader.sv
// tb_packed_act_stream_reader: random-stall stream checked beat by beat against a map-order model of the BRAM image
module tb_packed_act_stream_reader;
    localparam int IM_W = 32, IM_H = 32, NUM_FILT = 32, LAT = 1;
    localparam int PIX = IM_W * IM_H;
    localparam int TOTAL = NUM_FILT * PIX;
`ifdef PACKED_ACT_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, m_ready = 1'b0;
    logic [31:0] bram_dout = '0;
    logic bram_en, m_valid, m_last_ch, m_last, busy, done, range_err;
    logic [31:0] bram_addr;
    logic [3:0] m_data;
    logic [5:0] m_ch;
    logic [9:0] m_idx;
    logic [31:0] mem [TOTAL/8];
    int vectors = 0, errors = 0;
    int beats = 0, issued = 0, phase = 0, last_hs = 0, lastch_hs = 0;
    bit prev_stall = 0, exp_range = 0, rand_ready = 0;
    logic [3:0] pd;
    logic [5:0] pc;
    logic [9:0] pi;
    logic plc, pl;

    packed_act_stream_reader #(.IM_W(IM_W), .IM_H(IM_H), .NUM_FILT(NUM_FILT), .BRAM_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch), .m_idx(m_idx),
        .m_last_ch(m_last_ch), .m_last(m_last), .busy(busy), .done(done), .range_err(range_err)
    );

    always #5 clk = ~clk;
    // one-cycle-latency BRAM; idle cycles return noise
    always @(posedge clk) bram_dout <= bram_en ? mem[bram_addr[13:2]] : $urandom;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_nib(input int c, input int p);
        logic [31:0] w = mem[(c * PIX + p) / 8];
        return 4'((w >> (28 - 4 * (p % 8))) & 32'hF);
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            chk("reset_outs", {5'd0, bram_en, m_valid, m_last_ch, m_last, busy, done, range_err, m_data, m_ch, m_idx}, 32'd0);
            chk("reset_addr", bram_addr, 32'd0);
            phase = 0; beats = 0; issued = 0; prev_stall = 0; exp_range = 0;
        end else begin
            chk("busy", busy, phase == 1);
            chk("done", done, phase == 2);
            chk("range_err", range_err, exp_range);
            if (phase != 1) begin
                chk("idle_valid", m_valid, 0);
                chk("idle_en", bram_en, 0);
            end
            if (prev_stall && !abort)
                chk("stall_hold", {m_valid, m_data, m_ch, m_idx, m_last_ch, m_last}, {1'b1, pd, pc, pi, plc, pl});
            if (m_valid) begin
                chk("m_data", m_data, exp_nib(beats / PIX, beats % PIX));
                chk("m_ch", m_ch, beats / PIX);
                chk("m_idx", m_idx, beats % PIX);
                chk("m_last_ch", m_last_ch, beats % PIX == PIX - 1);
                chk("m_last", m_last, beats == TOTAL - 1);
            end
            if (bram_en && !abort) begin
                chk("bram_addr", bram_addr, issued * 4);
                chk("credit", (issued - beats / 8) < 2, 1);
            end
            if (abort) begin
                phase = 0; beats = 0; issued = 0; prev_stall = 0;
            end else begin
                if (phase == 1 && m_valid && m_ready) begin
                    if (RC && exp_nib(beats / PIX, beats % PIX) > 4'd6) exp_range = 1;
                    if (beats == TOTAL - 1) last_hs++;
                    if (beats % PIX == PIX - 1) lastch_hs++;
                    beats++;
                    if (beats == TOTAL) phase = 2;
                end else if (phase == 2) phase = 0;
                else if (phase == 0 && start) begin
                    phase = 1; beats = 0; issued = 0; exp_range = 0; last_hs = 0; lastch_hs = 0;
                end
                if (bram_en) issued++;
                prev_stall = m_valid && !m_ready;
                {pd, pc, pi, plc, pl} = {m_data, m_ch, m_idx, m_last_ch, m_last};
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        m_ready = rand_ready ? ($urandom_range(0, 99) < 70) : 1'b1;
    endtask

    initial begin
        int seq [8] = '{0, 1, 2, 3, 4, 5, 6, 0};
        bit seen;
        for (int i = 0; i < TOTAL / 8; i++) mem[i] = $urandom;
        mem[0] = 32'h0123_4560;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        reset = 0;
        step(); step();
        start = 1;
        step();
        start = 0;
        @(negedge clk);
        chk("first_en", bram_en, 1);
        chk("first_addr", bram_addr, 0);
        for (int i = 2; i <= 10; i++) begin
            step();
            @(negedge clk);
            chk("lat_valid", m_valid, i >= 3);
            if (i >= 3) begin
                chk("seq_data", m_data, seq[i-3]);
                chk("seq_idx", m_idx, i - 3);
                chk("seq_ch", m_ch, 0);
            end
        end
        repeat (30) step();
        chk("no_bubble", beats, 37);
        start = 1;
        step();
        start = 0;
        rand_ready = 1;
        seen = 0;
        for (int i = 0; i < 80000 && !seen; i++) begin
            step();
            if (done) begin
                seen = 1;
                chk("done_busy", busy, 0);
                chk("beat_total", beats, TOTAL);
                chk("last_count", last_hs, 1);
                chk("last_ch_count", lastch_hs, NUM_FILT);
            end
        end
        chk("run_complete", seen, 1);
        step();
        chk("done_pulse", done, 0);
        start = 1; abort = 1;
        step();
        start = 0; abort = 0;
        @(negedge clk);
        chk("start_abort_idle", busy, 0);
        step(); step();
        rand_ready = 0;
        mem[0] = 32'h7000_0000;
        start = 1;
        step();
        start = 0;
        @(negedge clk);
        chk("range_clr_start", range_err, 0);
        step(); step(); step();
        @(negedge clk);
        chk("range_first_beat", range_err, RC);
        rand_ready = 1;
        for (int g = 0; g < 5000 && beats < 500; g++) step();
        seen = 0;
        for (int g = 0; g < 50 && !seen; g++) begin
            step();
            @(negedge clk);
            seen = bram_en;
        end
        chk("abort_setup", seen, 1);
        @(posedge clk);
        #1;
        abort = 1;
        @(posedge clk);
        #1;
        abort = 0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_range_hold", range_err, RC);
        repeat (5) step();
        rand_ready = 0;
        start = 1;
        step();
        start = 0;
        @(negedge clk);
        chk("restart_addr", bram_addr, 0);
        chk("restart_en", bram_en, 1);
        step(); step();
        @(negedge clk);
        chk("restart_valid", m_valid, 1);
        chk("restart_ch", m_ch, 0);
        chk("restart_data", m_data, 7);
        rand_ready = 1;
        repeat (200) step();
        @(posedge clk);
        #3;
        reset = 1;
        #1;
        chk("async_rst", {busy, m_valid, bram_en, done, range_err, m_last, m_last_ch}, 0);
        chk("async_rst_cnt", {m_data, m_ch, m_idx}, 0);
        start = 1;
        repeat (2) @(posedge clk);
        #1;
        start = 0;
        reset = 0;
        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
